// File: rtl/ones_stats_pkg.sv
// ones_stats_pkg: shared state encoding and width helpers for the ones-count window statistics block
package ones_stats_pkg;
  typedef enum logic {ACCUM, HOLD} state_t;
  function automatic int sum_width(input int cnt_w, input int win_len);
    return cnt_w + $clog2(win_len);
  endfunction
  function automatic int n_width(input int win_len);
    return $clog2(win_len + 1);
  endfunction
endpackage

// File: rtl/ones_stats_acc.sv
// ones_stats_acc: running sum/max/min/sample-index datapath with clear and load strobes
module ones_stats_acc #(
  parameter int CNT_W = 5,
  parameter int SUM_W = 8,
  parameter int N_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] cnt,
  output logic [N_W-1:0]   idx,
  output logic [SUM_W-1:0] nxt_sum,
  output logic [CNT_W-1:0] nxt_max,
  output logic [CNT_W-1:0] nxt_min,
  output logic [N_W-1:0]   nxt_idx
);
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] max_q, min_q;
  // nxt_* already include this cycle's sample so a closing window can capture it directly
  always_comb begin
    nxt_sum = load ? sum + SUM_W'(cnt) : sum;
    nxt_max = (load && cnt > max_q) ? cnt : max_q;
    nxt_min = (load && cnt < min_q) ? cnt : min_q;
    nxt_idx = load ? idx + 1'b1 : idx;
  end
  always_ff @(posedge clk)
    if (!reset || clear) begin
      sum   <= '0;
      max_q <= '0;
      min_q <= '1;
      idx   <= '0;
    end else begin
      sum   <= nxt_sum;
      max_q <= nxt_max;
      min_q <= nxt_min;
      idx   <= nxt_idx;
    end
endmodule

// File: rtl/ones_window_stats.sv
// ones_window_stats: windowed sum/max/min/threshold statistics over popcount samples with valid/ready on both sides
module ones_window_stats
  import ones_stats_pkg::*;
#(
  parameter int CNT_W = 5,
  parameter int WIN_LEN = 8,
  parameter int SUM_W = sum_width(CNT_W, WIN_LEN),
  parameter int N_W = n_width(WIN_LEN),
  parameter int THRESH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_max,
  output logic [CNT_W-1:0] out_min,
  output logic [N_W-1:0]   out_n,
  output logic             out_over
);
  state_t state;
  logic xfer_in, xfer_out, close;
  logic [N_W-1:0] idx, nxt_idx;
  logic [SUM_W-1:0] nxt_sum;
  logic [CNT_W-1:0] nxt_max, nxt_min;
  assign in_ready  = state == ACCUM;
  assign out_valid = state == HOLD;
  always_comb begin
    xfer_in  = in_valid && in_ready;
    xfer_out = out_valid && out_ready;
    close    = in_ready && ((xfer_in && idx == N_W'(WIN_LEN - 1)) || (flush && (xfer_in || idx != '0)));
  end
  ones_stats_acc #(.CNT_W(CNT_W), .SUM_W(SUM_W), .N_W(N_W)) u_acc (
    .clk     (clk),
    .reset   (reset),
    .clear   (xfer_out),
    .load    (xfer_in),
    .cnt     (in_cnt),
    .idx     (idx),
    .nxt_sum (nxt_sum),
    .nxt_max (nxt_max),
    .nxt_min (nxt_min),
    .nxt_idx (nxt_idx)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      state    <= ACCUM;
      out_sum  <= '0;
      out_max  <= '0;
      out_min  <= '0;
      out_n    <= '0;
      out_over <= 1'b0;
    end else if (state == ACCUM) begin
      if (close) begin
        state    <= HOLD;
        out_sum  <= nxt_sum;
        out_max  <= nxt_max;
        out_min  <= nxt_min;
        out_n    <= nxt_idx;
        out_over <= nxt_sum >= SUM_W'(THRESH);
      end
    end else if (out_ready) begin
      state <= ACCUM;
    end
endmodule

// File: tb/tb_ones_window_stats.sv
// tb_ones_window_stats: scoreboard bench for ones_window_stats with directed and random windows
module tb_ones_window_stats;
  logic clk = 0, reset = 0, in_valid = 0, flush = 0, out_ready = 1;
  logic in_ready, out_valid, out_over;
  logic [4:0] in_cnt = 0, out_max, out_min;
  logic [7:0] out_sum;
  logic [3:0] out_n;
  typedef struct {
    logic [7:0] sum;
    logic [4:0] mx;
    logic [4:0] mn;
    logic [3:0] n;
    logic       over;
  } res_t;
  res_t q[$];
  int n_checks = 0, n_fail = 0, n_windows = 0;
  int m_sum = 0, m_max = 0, m_min = 31, m_n = 0;
  bit m_hold = 0, rand_rdy = 0;

  always #5 clk = ~clk;

  ones_window_stats dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_cnt(in_cnt),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_max(out_max), .out_min(out_min), .out_n(out_n), .out_over(out_over)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: pushes the expected result when a window closes, pops on output handshake
  always @(posedge clk) begin
    if (!reset) begin
      m_hold = 0; m_sum = 0; m_max = 0; m_min = 31; m_n = 0;
      q.delete();
    end else if (m_hold) begin
      if (out_ready) begin
        q.delete(0);
        n_windows++;
        m_hold = 0; m_sum = 0; m_max = 0; m_min = 31; m_n = 0;
      end
    end else begin
      if (in_valid) begin
        m_sum += in_cnt;
        if (in_cnt > m_max) m_max = in_cnt;
        if (in_cnt < m_min) m_min = in_cnt;
        m_n++;
      end
      if ((in_valid && m_n == 8) || (flush && m_n > 0)) begin
        q.push_back('{8'(m_sum), 5'(m_max), 5'(m_min), 4'(m_n), m_sum >= 64});
        m_hold = 1;
      end
    end
  end

  always @(negedge clk)
    if (reset) begin
      check("in_ready", in_ready, !m_hold);
      check("out_valid", out_valid, m_hold);
      if (m_hold) begin
        check("sb_size", q.size(), 1);
        if (q.size() == 1) begin
          check("sb_sum", out_sum, q[0].sum);
          check("sb_max", out_max, q[0].mx);
          check("sb_min", out_min, q[0].mn);
          check("sb_n", out_n, q[0].n);
          check("sb_over", out_over, q[0].over);
        end
      end
    end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic send(input logic [4:0] c, input logic f);
    bit ok = 0;
    in_valid = 1; in_cnt = c; flush = f;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    check("send_accept", ok, 1);
    in_valid = 0; flush = 0;
  endtask

  task automatic check_result(input string tag, input int s, input int mx, input int mn, input int n, input bit ov);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_sum"}, out_sum, s);
    check({tag, "_max"}, out_max, mx);
    check({tag, "_min"}, out_min, mn);
    check({tag, "_n"}, out_n, n);
    check({tag, "_over"}, out_over, ov);
  endtask

  initial begin
    int full[8] = '{3, 16, 0, 7, 8, 8, 1, 5};
    int base;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    foreach (full[i]) send(5'(full[i]), 0);
    check_result("full", 48, 16, 0, 8, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) send(5, 0);
    reset = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_sum", out_sum, 0);
    check("rst_max", out_max, 0);
    check("rst_min", out_min, 0);
    check("rst_n", out_n, 0);
    check("rst_over", out_over, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) send(16, 0);
    check_result("over", 128, 16, 16, 8, 1);
    @(posedge clk); #1;

    out_ready = 0;
    fork
      begin
        for (int i = 1; i <= 8; i++) send(5'(i), 0);
        for (int i = 0; i < 8; i++) send(2, 0);
      end
      begin
        for (int i = 0; i < 60 && !out_valid; i++) @(negedge clk);
        check("bp_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
          check("bp_sum", out_sum, 36);
          check("bp_in_ready", in_ready, 0);
          @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1;
      end
    join
    check_result("bp2", 16, 2, 2, 8, 0);
    @(posedge clk); #1;

    send(4, 0);
    send(9, 0);
    send(2, 1);
    check_result("flush", 15, 9, 2, 3, 0);
    @(posedge clk); #1;
    flush = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lone_flush", out_valid, 0);
    end
    @(posedge clk); #1 flush = 0;

    base = n_windows;
    rand_rdy = 1;
    for (int k = 0; k < 20000 && n_windows < base + 200; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        flush = 1'($urandom_range(0, 3) == 0);
        @(posedge clk); #1 flush = 0;
      end else begin
        logic [15:0] w;
        w = 16'($urandom());
        send(5'($countones(w)), 1'($urandom_range(0, 7) == 0));
      end
    end
    rand_rdy = 0;
    @(posedge clk); #1 out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rand_windows", n_windows >= base + 200, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
